// File: rtl/rop3_pkg.sv
// Shared ROP3 definitions: phase encoding on the operand bus and the supported mode codes.
package rop3_pkg;

    localparam int MODE_W = 8;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_LOAD_P = 2'd1;
    localparam logic [1:0] PH_LOAD_S = 2'd2;
    localparam logic [1:0] PH_LOAD_D = 2'd3;

    localparam logic [7:0] ROP_BLACKNESS   = 8'h00;
    localparam logic [7:0] ROP_NOTSRCERASE = 8'h11;
    localparam logic [7:0] ROP_NOTSRCCOPY  = 8'h33;
    localparam logic [7:0] ROP_SRCERASE    = 8'h44;
    localparam logic [7:0] ROP_DSTINVERT   = 8'h55;
    localparam logic [7:0] ROP_PATINVERT   = 8'h5A;
    localparam logic [7:0] ROP_SRCINVERT   = 8'h66;
    localparam logic [7:0] ROP_SRCAND      = 8'h88;
    localparam logic [7:0] ROP_MERGEPAINT  = 8'hBB;
    localparam logic [7:0] ROP_MERGECOPY   = 8'hC0;
    localparam logic [7:0] ROP_SRCCOPY     = 8'hCC;
    localparam logic [7:0] ROP_SRCPAINT    = 8'hEE;
    localparam logic [7:0] ROP_PATCOPY     = 8'hF0;
    localparam logic [7:0] ROP_PATPAINT    = 8'hFB;
    localparam logic [7:0] ROP_WHITENESS   = 8'hFF;

    localparam logic [7:0] ROP_CODES [15] = '{
        ROP_BLACKNESS, ROP_NOTSRCERASE, ROP_NOTSRCCOPY, ROP_SRCERASE, ROP_DSTINVERT,
        ROP_PATINVERT, ROP_SRCINVERT, ROP_SRCAND, ROP_MERGEPAINT, ROP_MERGECOPY,
        ROP_SRCCOPY, ROP_SRCPAINT, ROP_PATCOPY, ROP_PATPAINT, ROP_WHITENESS
    };

    // One FIFO entry holds {mode, p, s, d}.
    function automatic int entry_width(input int n);
        return MODE_W + 3 * n;
    endfunction

endpackage

// File: rtl/rop3_feeder_if.sv
// Request handshake plus serialised operand bus of the ROP3 feeder.
interface rop3_feeder_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_mode;
    logic [N-1:0] req_p;
    logic [N-1:0] req_s;
    logic [N-1:0] req_d;
    logic [N-1:0] bitmap;
    logic [7:0]   mode;
    logic [1:0]   phase;
    logic         busy;
    logic [LW-1:0] level;

    modport master (
        output req_valid, req_mode, req_p, req_s, req_d,
        input  req_ready, bitmap, mode, phase, busy, level
    );

    modport slave (
        input  req_valid, req_mode, req_p, req_s, req_d,
        output req_ready, bitmap, mode, phase, busy, level
    );

endinterface

// File: rtl/rop3_req_fifo.sv
// Request FIFO with registered occupancy count; head entry is read combinationally.
module rop3_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rop3_feeder.sv
// Buffers ROP3 requests and serialises P, S, D onto one bitmap bus, followed by an idle compute slot.
module rop3_feeder
    import rop3_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        srst,
    rop3_feeder_if.slave bus
);
    localparam int EW = entry_width(N);
    localparam int LW = $clog2(DEPTH + 1);

    logic [EW-1:0] wdata;
    logic [EW-1:0] head;
    logic [EW-1:0] held;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [LW-1:0] level;
    logic [1:0]    state;

    assign wdata         = {bus.req_mode, bus.req_p, bus.req_s, bus.req_d};
    assign bus.req_ready = !srst && !full;
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state == PH_IDLE) && !empty;
    assign bus.level     = level;
    assign bus.busy      = (bus.phase != PH_IDLE) || (level != '0);

    rop3_req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= PH_IDLE;
            held  <= '0;
        end else begin
            case (state)
                PH_IDLE: begin
                    if (!empty) begin
                        state <= PH_LOAD_P;
                        held  <= head;
                    end
                end
                PH_LOAD_P: state <= PH_LOAD_S;
                PH_LOAD_S: state <= PH_LOAD_D;
                default:   state <= PH_IDLE;
            endcase
        end
    end

    // Output stage registers the state's operand, so the bus trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            bus.phase  <= PH_IDLE;
            bus.bitmap <= '0;
            bus.mode   <= '0;
        end else begin
            bus.phase <= state;
            case (state)
                PH_LOAD_P: begin
                    bus.bitmap <= held[3*N-1 -: N];
                    bus.mode   <= held[EW-1 -: 8];
                end
                PH_LOAD_S: begin
                    bus.bitmap <= held[2*N-1 -: N];
                    bus.mode   <= held[EW-1 -: 8];
                end
                PH_LOAD_D: begin
                    bus.bitmap <= held[N-1:0];
                    bus.mode   <= held[EW-1 -: 8];
                end
                default: begin
                    bus.bitmap <= '0;
                    bus.mode   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rop3_feeder.sv
// Scoreboard bench for rop3_feeder: expected P/S/D beats queued at push, checked by a negedge monitor.
module tb_rop3_feeder;
    import rop3_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]  ph;
        logic [15:0] bm;
        logic [7:0]  md;
    } beat_t;

    logic clk  = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    rop3_feeder_if #(.N(8),  .DEPTH(DEPTH)) b8();
    rop3_feeder_if #(.N(16), .DEPTH(DEPTH)) b16();

    rop3_feeder #(.N(8),  .DEPTH(DEPTH)) dut8  (.clk(clk), .srst(srst), .bus(b8));
    rop3_feeder #(.N(16), .DEPTH(DEPTH)) dut16 (.clk(clk), .srst(srst), .bus(b16));

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    beat_t exp_q[$];
    int    p_times[$];
    int    max_level = 0;
    logic  saw_full  = 1'b0;
    logic [1:0] prev_ph = PH_IDLE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-idle beat must be the next expected one, in order.
    always @(negedge clk) begin
        beat_t e;
        if (b8.phase != PH_IDLE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(b8.phase), 32'(PH_IDLE));
            end else begin
                e = exp_q.pop_front();
                check("beat_phase",  32'(b8.phase),  32'(e.ph));
                check("beat_bitmap", 32'(b8.bitmap), 32'(e.bm));
                check("beat_mode",   32'(b8.mode),   32'(e.md));
            end
            if (b8.phase == PH_LOAD_P) p_times.push_back(cyc);
        end else begin
            check("idle_bitmap", 32'(b8.bitmap), 0);
            check("idle_mode",   32'(b8.mode),   0);
        end
        if (prev_ph == PH_LOAD_D) check("idle_after_d", 32'(b8.phase), 32'(PH_IDLE));
        check("ready_rule", 32'(b8.req_ready), 32'(!srst && (int'(b8.level) != DEPTH)));
        check("busy_rule",  32'(b8.busy), 32'((b8.phase != PH_IDLE) || (b8.level != 0)));
        check("level_bound", 32'(int'(b8.level) > DEPTH), 0);
        if (int'(b8.level) > max_level) max_level = int'(b8.level);
        if (int'(b8.level) == DEPTH) saw_full = 1'b1;
        prev_ph = b8.phase;
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send8(input logic [7:0] m, input logic [7:0] p, input logic [7:0] s,
                         input logic [7:0] d);
        logic acc;
        int   w;
        w = 0;
        acc = 1'b0;
        b8.req_valid = 1'b1;
        b8.req_mode  = m;
        b8.req_p     = p;
        b8.req_s     = s;
        b8.req_d     = d;
        forever begin
            acc = b8.req_ready;
            @(posedge clk); #1;
            if (acc) break;
            w++;
            if (w > 200) begin
                check("push_timeout", 32'(acc), 1);
                break;
            end
        end
        b8.req_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(beat_t'{PH_LOAD_P, {8'h00, p}, m});
            exp_q.push_back(beat_t'{PH_LOAD_S, {8'h00, s}, m});
            exp_q.push_back(beat_t'{PH_LOAD_D, {8'h00, d}, m});
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((b8.busy || b8.phase != PH_IDLE || exp_q.size() != 0) && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_busy",  32'(b8.busy), 0);
        check("drain_queue", 32'(exp_q.size()), 0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        b8.req_valid  = 1'b0; b8.req_mode  = '0; b8.req_p  = '0; b8.req_s  = '0; b8.req_d  = '0;
        b16.req_valid = 1'b0; b16.req_mode = '0; b16.req_p = '0; b16.req_s = '0; b16.req_d = '0;

        // Reset then idle
        srst = 1'b1;
        repeat (2) step();
        check("rst_ready",  32'(b8.req_ready), 0);
        check("rst_phase",  32'(b8.phase),     0);
        check("rst_bitmap", 32'(b8.bitmap),    0);
        check("rst_mode",   32'(b8.mode),      0);
        check("rst_level",  32'(b8.level),     0);
        srst = 1'b0;
        step();
        check("post_rst_ready", 32'(b8.req_ready), 1);
        check("post_rst_phase", 32'(b8.phase),     0);

        // Single request latency
        send8(8'h5A, 8'hA5, 8'h3C, 8'h0F);
        check("single_level_t", 32'(b8.level), 1);
        step();
        check("single_level_t1", 32'(b8.level), 0);
        check("single_phase_t1", 32'(b8.phase), 0);
        step();
        check("single_phase_t2", 32'(b8.phase), 1);
        check("single_bm_t2",    32'(b8.bitmap), 32'h A5);
        check("single_mode_t2",  32'(b8.mode),   32'h5A);
        step();
        check("single_phase_t3", 32'(b8.phase), 2);
        check("single_bm_t3",    32'(b8.bitmap), 32'h3C);
        step();
        check("single_phase_t4", 32'(b8.phase), 3);
        check("single_bm_t4",    32'(b8.bitmap), 32'h0F);
        check("single_mode_t4",  32'(b8.mode),   32'h5A);
        step();
        check("single_phase_t5", 32'(b8.phase), 0);
        check("single_bm_t5",    32'(b8.bitmap), 0);
        check("single_mode_t5",  32'(b8.mode),   0);
        wait_idle();

        // Back-to-back: three pushes on consecutive cycles
        p_times.delete();
        max_level = 0;
        for (int i = 0; i < 3; i++)
            send8(ROP_CODES[$urandom_range(0, 14)], 8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle();
        check("b2b_count", 32'(p_times.size()), 3);
        if (p_times.size() == 3) begin
            check("b2b_gap0", 32'(p_times[1] - p_times[0]), 4);
            check("b2b_gap1", 32'(p_times[2] - p_times[1]), 4);
        end
        check("b2b_peak", 32'(max_level), 2);

        // Full backpressure with valid held across a long burst
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++)
            send8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle();
        check("full_seen", 32'(saw_full), 1);

        // Randomized traffic with random gaps
        for (int i = 0; i < 40; i++) begin
            send8(($urandom_range(0, 1) != 0) ? ROP_CODES[$urandom_range(0, 14)] : 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 4)) step();
        end
        wait_idle();

        // Reset while LOAD_S is on the bus with two entries queued
        for (int i = 0; i < 3; i++)
            send8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        w = 0;
        while (b8.phase != PH_LOAD_S && w < 50) begin
            step();
            w++;
        end
        check("mid_reach_load_s", 32'(b8.phase), 32'(PH_LOAD_S));
        check("mid_level", 32'(b8.level), 2);
        srst = 1'b1;
        #1;
        check("mid_ready_in_rst", 32'(b8.req_ready), 0);
        @(posedge clk); #1;
        exp_q.delete();
        check("mid_phase",  32'(b8.phase),  0);
        check("mid_bitmap", 32'(b8.bitmap), 0);
        check("mid_mode",   32'(b8.mode),   0);
        check("mid_level0", 32'(b8.level),  0);
        srst = 1'b0;
        repeat (12) step();
        check("mid_after_phase", 32'(b8.phase), 0);
        check("mid_after_level", 32'(b8.level), 0);

        // Width sweep on the N=16 instance
        b16.req_valid = 1'b1;
        b16.req_mode  = ROP_MERGECOPY;
        b16.req_p     = 16'hFFFF;
        b16.req_s     = 16'h1234;
        b16.req_d     = 16'hBEEF;
        check("w16_ready", 32'(b16.req_ready), 1);
        step();
        b16.req_valid = 1'b0;
        step();
        step();
        check("w16_phase_p", 32'(b16.phase),  1);
        check("w16_bm_p",    32'(b16.bitmap), 32'hFFFF);
        check("w16_mode_p",  32'(b16.mode),   32'hC0);
        step();
        check("w16_phase_s", 32'(b16.phase),  2);
        check("w16_bm_s",    32'(b16.bitmap), 32'h1234);
        step();
        check("w16_phase_d", 32'(b16.phase),  3);
        check("w16_bm_d",    32'(b16.bitmap), 32'hBEEF);
        check("w16_mode_d",  32'(b16.mode),   32'hC0);
        step();
        check("w16_phase_i", 32'(b16.phase),  0);
        check("w16_bm_i",    32'(b16.bitmap), 0);

        check("final_queue", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
